// File: rtl/display_scan_mux.sv
// Time-multiplexed digit scanner: walks a select index across N_DIGITS at a
// prescaled rate, driving a registered digit code and a one-hot anode enable.
module display_scan_mux #(
    parameter int N_DIGITS   = 8,
    parameter int NIB_W      = 4,
    parameter int TICK_DIV   = 100000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [N_DIGITS*NIB_W-1:0]                         digits,
    input  logic [N_DIGITS-1:0]                               blank,
    input  logic                                              load,
    output logic [((N_DIGITS > 1) ? $clog2(N_DIGITS) : 1)-1:0] sel,
    output logic [NIB_W-1:0]                                  digit_out,
    output logic [N_DIGITS-1:0]                               anode,
    output logic                                              frame_done
);

    localparam int SEL_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] ANODE_OFF =
        (ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    logic [CNT_W-1:0]    presc_reg;
    logic                tick;
    logic [SEL_W-1:0]    sel_reg;
    logic [NIB_W-1:0]    shadow_reg [N_DIGITS];
    logic [NIB_W-1:0]    digit_out_reg;
    logic [N_DIGITS-1:0] anode_reg;
    logic [N_DIGITS-1:0] anode_next;
    logic                frame_done_reg;

    // With TICK_DIV = 1 the counter sits at 0 == CNT_LAST, so tick is constant.
    assign tick = (presc_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_reg        <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= tick && (sel_reg == SEL_LAST);
            if (tick) begin
                sel_reg <= (sel_reg == SEL_LAST) ? '0 : sel_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                shadow_reg[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                shadow_reg[i] <= digits[i*NIB_W +: NIB_W];
            end
        end
    end

    // Blank is applied live here; it never touches the code path.
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_anode
            logic lit;
            assign lit            = (sel_reg == SEL_W'(gi)) && !blank[gi];
            assign anode_next[gi] = (ACTIVE_LOW != 0) ? ~lit : lit;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_out_reg <= '0;
            anode_reg     <= ANODE_OFF;
        end else begin
            digit_out_reg <= shadow_reg[sel_reg];
            anode_reg     <= anode_next;
        end
    end

    assign sel        = sel_reg;
    assign digit_out  = digit_out_reg;
    assign anode      = anode_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench: a cycle-count reference model predicts every output of an
// 8-digit build and a 1-digit/TICK_DIV=1 build, compared one edge later.
module tb_display_scan_mux;

    localparam int N = 8;
    localparam int W = 4;
    localparam int D = 4;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic [31:0]  digits = '0;
    logic [7:0]   blank  = '0;
    logic         load   = 1'b0;
    logic [2:0]   sel;
    logic [3:0]   digit_out;
    logic [7:0]   anode;
    logic         frame_done;

    logic [0:0]   blank1 = 1'b0;
    logic [0:0]   sel1;
    logic [3:0]   digit_out1;
    logic [0:0]   anode1;
    logic         frame_done1;

    display_scan_mux #(.N_DIGITS(N), .NIB_W(W), .TICK_DIV(D), .ACTIVE_LOW(1)) u_dut (
        .clk(clk), .reset(reset), .digits(digits), .blank(blank), .load(load),
        .sel(sel), .digit_out(digit_out), .anode(anode), .frame_done(frame_done)
    );

    display_scan_mux #(.N_DIGITS(1), .NIB_W(W), .TICK_DIV(1), .ACTIVE_LOW(1)) u_dut1 (
        .clk(clk), .reset(reset), .digits(digits[3:0]), .blank(blank1), .load(load),
        .sel(sel1), .digit_out(digit_out1), .anode(anode1), .frame_done(frame_done1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sel;
        logic [3:0] dig;
        logic [7:0] an;
        logic       fd;
        logic [3:0] dig1;
        logic       an1;
        logic       fd1;
    } exp_t;

    exp_t       exp_q[$];
    int         t;              // non-reset edges since the last reset edge
    logic [3:0] sh [N];
    logic [3:0] sh1;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, want, t);
        end
    endtask

    task automatic step();
        exp_t e;
        int   sb;
        if (reset) begin
            t = 0;
            for (int i = 0; i < N; i++) sh[i] = '0;
            sh1   = '0;
            e.sel = '0; e.dig = '0; e.an = 8'hFF; e.fd = 1'b0;
            e.dig1 = '0; e.an1 = 1'b1; e.fd1 = 1'b0;
        end else begin
            sb    = (t / D) % N;
            e.dig = sh[sb];
            e.an  = blank[sb] ? 8'hFF : ~(8'h01 << sb);
            t++;
            e.sel  = 3'((t / D) % N);
            e.fd   = (t % (D * N)) == 0;
            e.dig1 = sh1;
            e.an1  = blank1[0];
            e.fd1  = 1'b1;
            if (load) begin
                for (int i = 0; i < N; i++) sh[i] = digits[i*W +: W];
                sh1 = digits[3:0];
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("sel",         32'(sel),         32'(e.sel));
        check("digit_out",   32'(digit_out),   32'(e.dig));
        check("anode",       32'(anode),       32'(e.an));
        check("frame_done",  32'(frame_done),  32'(e.fd));
        check("sel1",        32'(sel1),        32'd0);
        check("digit_out1",  32'(digit_out1),  32'(e.dig1));
        check("anode1",      32'(anode1),      32'(e.an1));
        check("frame_done1", 32'(frame_done1), 32'(e.fd1));
        $display("t=%0d rst=%b ld=%b blank=%h sel=%0d dig=%h an=%h fd=%b | dig1=%h an1=%b fd1=%b",
                 t, reset, load, blank, sel, digit_out, anode, frame_done,
                 digit_out1, anode1, frame_done1);
    endtask

    initial begin
        // Reset for two edges, then release while loading the first pattern.
        reset = 1'b1;
        repeat (2) step();
        reset  = 1'b0;
        digits = 32'h7654_3210;
        load   = 1'b1;
        step();
        load = 1'b0;
        repeat (40) step();

        // Blank digits 1 and 3 for a full frame.
        blank = 8'h0A;
        repeat (32) step();
        blank = 8'h00;

        // Change digits without load, then load exactly on a tick cycle.
        digits = 32'hFFFF_FFFF;
        repeat (8) step();
        for (int i = 0; i < 2 * D && (t % D) != D - 1; i++) step();
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (12) step();

        // All-blank frame keeps scanning with anodes dark.
        blank  = 8'hFF;
        blank1 = 1'b1;
        repeat (34) step();
        blank  = 8'h00;
        blank1 = 1'b0;

        // Abort mid-dwell at sel 5, with load asserted to show reset dominates.
        for (int i = 0; i < 2 * D * N && !(((t / D) % N) == 5 && (t % D) == 1); i++) step();
        reset = 1'b1;
        load  = 1'b1;
        step();
        reset = 1'b0;
        load  = 1'b0;
        repeat (40) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_mux.md
DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
REQ-001 Parameter N_DIGITS, default 8, number of display digits scanned (legal range 1-16).
REQ-002 Parameter NIB_W, default 4, width of each digit code in bits.
REQ-003 Parameter TICK_DIV, default 100000, clocks per digit dwell (legal range 1 to 2^24).
REQ-004 Parameter ACTIVE_LOW, default 1; 1 = anode asserted low, 0 = asserted high.
REQ-005 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port digits  input  N_DIGITS*NIB_W  packed digit codes; digit i at bits [i*NIB_W +: NIB_W].
REQ-008 Port blank  input  N_DIGITS  per-digit blank mask; bit i = 1 keeps digit i dark.
REQ-009 Port load  input  1  capture digits into shadow register.
REQ-010 Port sel  output  max(1,clog2(N_DIGITS))  index of digit currently scanned.
REQ-011 Port digit_out  output  NIB_W  code of digit being displayed, registered.
REQ-012 Port anode  output  N_DIGITS  one-hot (polarity per ACTIVE_LOW) digit enable, registered.
REQ-013 Port frame_done  output  1  one-cycle pulse when scan wraps from last digit to digit 0.

Function
REQ-014 Prescaler counts 0..TICK_DIV-1 and wraps to 0; internal tick asserted in the cycle count == TICK_DIV-1.
REQ-015 TICK_DIV = 1 shall assert tick every cycle.
REQ-016 On tick, sel advances by 1; from N_DIGITS-1 it wraps to 0; no other sel change.
REQ-017 frame_done registered high for exactly the one cycle following the tick that wraps sel to 0; low otherwise.
REQ-018 N_DIGITS = 1: sel constant 0; frame_done pulses after every tick.
REQ-019 load high at an edge copies digits into shadow at that edge; shadow holds while load low.
REQ-020 Each edge: digit_out <= shadow[sel]; anode <= one-hot(sel) with bit cleared if blank[sel], inverted when ACTIVE_LOW = 1.
REQ-021 digit_out and anode lag sel by exactly one cycle and always describe the same digit.
REQ-022 Latency: load at edge k -> new code on digit_out at edge k+1 if that digit is selected.
REQ-023 load and tick in same cycle: both take effect; output at next edge uses new shadow and new sel.
REQ-024 blank affects anode only; digit_out still carries shadow[sel]; blank is not shadowed (live).
REQ-025 All-blank mask: anode all inactive; scan and frame_done continue unchanged.
REQ-026 No combinational path from any input to any output.

Reset
REQ-027 reset dominates load and tick in the same cycle.
REQ-028 At the edge sampling reset = 1: prescaler 0, sel 0, shadow 0, digit_out 0, frame_done 0, anode all inactive (all 1s if ACTIVE_LOW).
REQ-029 Reset mid-scan aborts the dwell; first tick after release occurs TICK_DIV cycles after the first non-reset edge.
REQ-030 First non-reset edge drives anode to digit 0 active (unless blank[0]) and digit_out = shadow[0] = 0.

Verification (N_DIGITS=8, NIB_W=4, TICK_DIV=4, ACTIVE_LOW=1)
REQ-031 Reset 2 cycles, release -> anode 0xFF during reset, 0xFE next cycle, digit_out 0, sel 0.
REQ-032 digits = 0x76543210, load 1 cycle, run 32 cycles -> digit_out steps 0..7 every 4 cycles; anode 0xFE,0xFD..0x7F; frame_done one pulse per 32 cycles.
REQ-033 blank = 0x0A during scan -> anode stays 0xFF while sel = 1 and 3; digit_out still 1 and 3.
REQ-034 digits changed to 0xFFFFFFFF without load -> digit_out unchanged; pulse load in a tick cycle -> next output F at new sel.
REQ-035 reset asserted at sel = 5 mid-dwell -> next edge all outputs at reset values; shadow cleared, frame_done not pulsed.
REQ-036 TICK_DIV=1, N_DIGITS=1 build -> sel 0, anode 0x0 (bit 0 low), frame_done high every cycle after release.
